alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//  Instruction sequencer and command issuer for the 8-bit core; the producer side of the ALU command interface.
//  Fetches 8-bit instructions over a req/valid instruction-memory handshake and decodes them.
//  Drives ALU cmd/immediate and register-file read/write addresses, and sequences PC update and halt.
//  Sits between instruction memory and the datapath (regfile + ALU); owns no data values itself.
// PARAMETERS
//  PCW       8     PC / imem address width; PC arithmetic is modulo 2**PCW
//  RESET_PC  '0    PC value loaded on reset and on each start
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      pulse: begin execution at RESET_PC; honoured only in IDLE or HALTED
//  imem_req    out  1      fetch request
//  imem_addr   out  PCW    fetch address (= PC)
//  imem_valid  in   1      imem_rdata valid this cycle
//  imem_rdata  in   8      instruction word
//  rf_ra       out  2      regfile read port A address (ALU a)
//  rf_rb       out  2      regfile read port B address (ALU b)
//  rf_we       out  1      regfile write enable (ALU result -> rf_ra register)
//  alu_cmd     out  AluCmd ALU command (ADD/NAND/SHFT)
//  alu_n       out  Immed  ALU immediate {flag, shamt[2:0]}; flag=1 right shift
//  busy        out  1      state not in {IDLE, HALTED}
//  halted      out  1      state == HALTED
// BEHAVIOUR
//  Encoding ir[7:6]:
//   00 ADD  ra=ir[5:4] rb=ir[3:2]   R[ra] <= R[ra]+R[rb]
//   01 NAND ra=ir[5:4] rb=ir[3:2]   R[ra] <= ~(R[ra]&R[rb])
//   10 SHFT ra=ir[5:4] n=ir[3:0]    R[ra] <= shift(R[ra], n)
//   11 JMP  off=ir[5:0] signed      PC <= PC+sext(off); off==0 => HALT
//  ir[1:0] of ADD/NAND are ignored.
//  States: IDLE -> FETCH -> DECODE -> EXEC -> FETCH ... and HALTED.
//   IDLE:   start -> PC=RESET_PC, go to FETCH.
//   FETCH:  imem_req=1, imem_addr=PC, both held stable until imem_valid.
//           On req&valid, IR<=imem_rdata and go to DECODE. No timeout.
//   DECODE: one cycle. rf_ra/rf_rb/alu_cmd/alu_n are valid from IR; rf_we=0.
//   EXEC:   ALU ops: rf_we=1 for exactly this cycle, PC<=PC+1, go to FETCH.
//           JMP off!=0: rf_we=0, PC<=PC+sext(off), go to FETCH.
//           JMP off==0: PC unchanged, go to HALTED.
//   HALTED: start -> PC=RESET_PC, go to FETCH; otherwise hold.
//  alu_cmd/alu_n/rf_ra/rf_rb are combinational from IR in every state. JMP maps alu_cmd=ADD, alu_n=IR[3:0].
//  alu_cmd is never X, so the ALU default branch is unreachable.
//  Throughput: 3 cycles per instruction + imem wait cycles (zero-wait imem: FETCH 1 cycle).
//  PC wraps: 2**PCW-1 +1 -> 0; JMP sums truncate to PCW bits.
//  start while busy: ignored. start on the same edge as the HALT EXEC: HALT wins; start is seen next cycle.
//  Reset (async, any state):
//   state=IDLE, PC=RESET_PC, IR=8'h00.
//   imem_req=0, rf_we=0, busy=0, halted=0, alu_cmd=ADD, alu_n='0, rf_ra=rf_rb=0.
//   An in-flight fetch is abandoned; imem must tolerate a dropped req.
//  Every output is a register or decoded from registers only; there is no in->out combinational path.
// STRUCTURE
//  Package alu gains:
//   Opcode enum {OP_ADD, OP_NAND, OP_SHFT, OP_JMP}
//   Instr packed union (rr form / shift form / jmp form)
//   SeqState enum
//  AluCmd and Immed are reused unchanged.
//  Sub-module instr_decode (combinational: IR -> ra, rb, cmd, n, is_jmp, off) keeps the FSM file to PC/state/handshake.
// TESTING
//  1. Reset with rst_n=0 mid-FETCH -> imem_req=0, busy=0, rf_we=0 the same cycle (async); PC=RESET_PC after release.
//  2. start; imem zero-wait returns 8'h24 (ADD r2,r1) -> rf_ra=2, rf_rb=1, alu_cmd=ADD, rf_we=1 for exactly 1 cycle, 3 cycles after start; next imem_addr=1.
//  3. imem_valid held low 4 cycles on fetch of 8'hBB (SHFT r3, n=4'hB) -> imem_addr stable for all 4 cycles, then alu_cmd=SHFT, alu_n={1,3'd3}, rf_ra=3.
//  4. PC=8'hFF executing ADD -> next imem_addr=8'h00 (wrap).
//  5. JMP off=6'h3E (-2) at PC=5 -> next imem_addr=3, rf_we never asserted.
//  6. JMP off=0 (8'hC0) -> halted=1, busy=0, no further imem_req; start -> imem_addr=RESET_PC; start pulsed while busy -> no effect.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// ============================================================================
// Module : alu_sequencer_pkg
// Brief  : Shared ALU command types and sequencer instruction/state types.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_sequencer_pkg;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_NAND = 2'd1,
        ALU_SHFT = 2'd2
    } AluCmd;

    // flag=1 selects a right shift
    typedef struct packed {
        logic       flag;
        logic [2:0] shamt;
    } Immed;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_NAND = 2'd1,
        OP_SHFT = 2'd2,
        OP_JMP  = 2'd3
    } Opcode;

    typedef struct packed {
        Opcode      op;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [1:0] rsvd;
    } InstrRR;

    typedef struct packed {
        Opcode      op;
        logic [1:0] ra;
        Immed       n;
    } InstrSh;

    typedef struct packed {
        Opcode      op;
        logic [5:0] off;
    } InstrJmp;

    typedef union packed {
        InstrRR  rr;
        InstrSh  sh;
        InstrJmp jmp;
    } Instr;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALTED = 3'd4
    } SeqState;

    // Jumps borrow the ADD command so alu_cmd is always a legal encoding
    function automatic AluCmd op_to_cmd(input Opcode op);
        AluCmd cmd;
        case (op)
            OP_NAND: cmd = ALU_NAND;
            OP_SHFT: cmd = ALU_SHFT;
            default: cmd = ALU_ADD;
        endcase
        return cmd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_instr_decode.sv
// ============================================================================
// Module : alu_sequencer_instr_decode
// Brief  : Combinational instruction decoder, IR -> ALU/regfile controls.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_sequencer_instr_decode
    import alu_sequencer_pkg::*;
(
    input  Instr        ir,
    output logic [1:0]  ra,
    output logic [1:0]  rb,
    output AluCmd       cmd,
    output Immed        n,
    output logic        is_jmp,
    output logic [5:0]  off
);

    // Field positions are shared by all forms, so no opcode muxing is needed
    assign ra     = ir.rr.ra;
    assign rb     = ir.rr.rb;
    assign n      = ir.sh.n;
    assign off    = ir.jmp.off;
    assign is_jmp = (ir.rr.op == OP_JMP);
    assign cmd    = op_to_cmd(ir.rr.op);

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module : alu_sequencer
// Brief  : Fetch/decode/execute sequencer driving the ALU and regfile controls.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int              PCW      = 8,
    parameter logic [PCW-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PCW-1:0]  imem_addr,
    input  logic            imem_valid,
    input  logic [7:0]      imem_rdata,
    output logic [1:0]      rf_ra,
    output logic [1:0]      rf_rb,
    output logic            rf_we,
    output AluCmd           alu_cmd,
    output Immed            alu_n,
    output logic            busy,
    output logic            halted
);

    SeqState          r_state;
    SeqState          w_state_next;
    logic [PCW-1:0]   r_pc;
    logic [PCW-1:0]   w_pc_next;
    Instr             r_ir;
    Instr             w_ir_next;

    logic             w_is_jmp;
    logic [5:0]       w_off;
    logic [PCW-1:0]   w_off_ext;

    alu_sequencer_instr_decode u_decode (
        .ir     (r_ir),
        .ra     (rf_ra),
        .rb     (rf_rb),
        .cmd    (alu_cmd),
        .n      (alu_n),
        .is_jmp (w_is_jmp),
        .off    (w_off)
    );

    assign w_off_ext = PCW'(signed'(w_off));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ir    <= w_ir_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        case (r_state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    w_state_next = S_FETCH;
                    w_pc_next    = RESET_PC;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    w_ir_next    = imem_rdata;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                if (!w_is_jmp) begin
                    w_pc_next    = r_pc + PCW'(1);
                    w_state_next = S_FETCH;
                end else if (w_off == 6'd0) begin
                    // Zero-offset jump is the halt instruction
                    w_state_next = S_HALTED;
                end else begin
                    w_pc_next    = r_pc + w_off_ext;
                    w_state_next = S_FETCH;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign rf_we     = (r_state == S_EXEC) && !w_is_jmp;
    assign busy      = (r_state != S_IDLE) && (r_state != S_HALTED);
    assign halted    = (r_state == S_HALTED);

endmodule

`default_nettype wire
